// File: rtl/can_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : can_bus_sequencer
// Purpose  : Bus-cycle controller for an external CAN controller on an 8-bit
//            multiplexed (Intel-mode) parallel bus. Arbitrates between two
//            internal requesters and runs one register read or write at a
//            time: ALE address phase, then RD/WR strobe data phase. Also
//            synchronises the active-low CAN interrupt line.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req0/req1             request (held with we/addr/wdata until ack)
//   we0/we1               1 = write, 0 = read
//   addr0/addr1           CAN register address
//   wdata0/wdata1         write data
//   ack0/ack1             one-cycle completion pulse
//   rdata                 read data, valid with ack, held until next read
//   busy                  high from grant through end of recovery
//   can_ad_o/can_ad_oe    multiplexed AD bus output and its drive enable
//   can_ad_i              AD bus input
//   can_ale               address latch enable (active high)
//   can_cs/can_wr/can_rd  chip select / write / read strobes (active low)
//   can_int               CAN interrupt (active low, asynchronous)
//   irq                   synchronised interrupt (active high)
// Configuration macro:
//   CAN_ARB_RR_EN  defined   -> round-robin arbitration
//                  undefined -> fixed priority, req0 over req1
// ============================================================================
module can_bus_sequencer #(
   parameter int unsigned T_ALE    = 2,
   parameter int unsigned T_STROBE = 3,
   parameter int unsigned T_HOLD   = 1,
   parameter int unsigned T_RECOV  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic       we0,
   input  logic       we1,
   input  logic [7:0] addr0,
   input  logic [7:0] addr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic       ack0,
   output logic       ack1,
   output logic [7:0] rdata,
   output logic       busy,
   output logic [7:0] can_ad_o,
   output logic       can_ad_oe,
   input  logic [7:0] can_ad_i,
   output logic       can_ale,
   output logic       can_cs,
   output logic       can_wr,
   output logic       can_rd,
   input  logic       can_int,
   output logic       irq
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR   = 3'd1,
      S_LATCH  = 3'd2,
      S_STROBE = 3'd3,
      S_HOLD   = 3'd4,
      S_DONE   = 3'd5,
      S_RECOV  = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               gnt_q;
   logic               we_q;
   logic [7:0]         addr_q;
   logic [7:0]         wdata_q;
   logic [7:0]         rcap_q;
   logic [7:0]         rdata_q;
   logic [7:0]         ad_o_q;
   logic               oe_q, ale_q, cs_q, wr_q, rd_q, busy_q;
   logic [1:0]         ack_q;
   logic               int_s1_q, int_s2_q;

   logic               w_last;
   logic               w_pick1;
   logic               w_grant;

`ifdef CAN_ARB_RR_EN
   logic               last_grant_q;
   // Requester granted last yields when both are pending.
   assign w_pick1 = req1 & (~req0 | ~last_grant_q);
`else
   assign w_pick1 = req1 & ~req0;
`endif

   assign w_last  = (cnt_q == '0);
   assign w_grant = (state_q == S_IDLE) && (req0 || req1);

   // Next-state and phase counter; cnt_q holds cycles remaining in the phase.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               state_d = S_ADDR;
               cnt_d   = CNT_W'(T_ALE - 1);
            end
         end
         S_ADDR: begin
            if (w_last) begin
               state_d = S_LATCH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_LATCH: begin
            state_d = S_STROBE;
            cnt_d   = CNT_W'(T_STROBE - 1);
         end
         S_STROBE: begin
            if (w_last) begin
               state_d = S_HOLD;
               cnt_d   = CNT_W'(T_HOLD - 1);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_HOLD: begin
            if (w_last) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_RECOV;
            cnt_d   = CNT_W'(T_RECOV - 1);
         end
         S_RECOV: begin
            if (w_last) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // All bus outputs are decoded from the next state and registered, so the
   // pins change only on a clock edge (or on async reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         gnt_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rcap_q   <= '0;
         rdata_q  <= '0;
         ad_o_q   <= '0;
         oe_q     <= 1'b0;
         ale_q    <= 1'b0;
         cs_q     <= 1'b1;
         wr_q     <= 1'b1;
         rd_q     <= 1'b1;
         busy_q   <= 1'b0;
         ack_q    <= '0;
         int_s1_q <= 1'b1;
         int_s2_q <= 1'b1;
`ifdef CAN_ARB_RR_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         int_s1_q <= can_int;
         int_s2_q <= int_s1_q;

         if (w_grant) begin
            gnt_q   <= w_pick1;
            we_q    <= w_pick1 ? we1    : we0;
            addr_q  <= w_pick1 ? addr1  : addr0;
            wdata_q <= w_pick1 ? wdata1 : wdata0;
`ifdef CAN_ARB_RR_EN
            last_grant_q <= w_pick1;
`endif
         end

         // Read data is sampled on the final strobe cycle.
         if (state_q == S_STROBE && w_last && !we_q) begin
            rcap_q <= can_ad_i;
         end

         // On grant the latched fields are not yet valid, so drive the
         // address straight from the winning requester.
         if (w_grant) begin
            ad_o_q <= w_pick1 ? addr1 : addr0;
         end else if (state_q == S_LATCH && state_d == S_STROBE && we_q) begin
            ad_o_q <= wdata_q;
         end

         ale_q  <= (state_d == S_ADDR);
         cs_q   <= !(state_d == S_ADDR || state_d == S_LATCH ||
                     state_d == S_STROBE || state_d == S_HOLD);
         wr_q   <= !(state_d == S_STROBE && we_q);
         rd_q   <= !(state_d == S_STROBE && !we_q);
         oe_q   <= (state_d == S_ADDR) || (state_d == S_LATCH) ||
                   (we_q && (state_d == S_STROBE || state_d == S_HOLD));
         busy_q <= (state_d != S_IDLE);

         ack_q[0] <= (state_d == S_DONE) && !gnt_q;
         ack_q[1] <= (state_d == S_DONE) &&  gnt_q;

         if (state_d == S_DONE && !we_q) begin
            rdata_q <= rcap_q;
         end
      end
   end

   assign ack0      = ack_q[0];
   assign ack1      = ack_q[1];
   assign rdata     = rdata_q;
   assign busy      = busy_q;
   assign can_ad_o  = ad_o_q;
   assign can_ad_oe = oe_q;
   assign can_ale   = ale_q;
   assign can_cs    = cs_q;
   assign can_wr    = wr_q;
   assign can_rd    = rd_q;
   assign irq       = ~int_s2_q;

endmodule
`default_nettype wire

// File: tb/tb_can_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_bus_sequencer
// Purpose  : Self-checking bench for can_bus_sequencer. Stimulus pushes the
//            expected ack (port, rdata) into a scoreboard; a monitor pops and
//            compares whenever an ack pulse appears. Bus phases, latency,
//            interrupt sync and async reset are checked directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_can_bus_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, we0, we1;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic       ack0, ack1;
   logic [7:0] rdata;
   logic       busy;
   logic [7:0] can_ad_o;
   logic       can_ad_oe;
   logic [7:0] can_ad_i;
   logic       can_ale, can_cs, can_wr, can_rd;
   logic       can_int;
   logic       irq;

   always #5 clk = ~clk;

   can_bus_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .req1      (req1),
      .we0       (we0),
      .we1       (we1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .ack0      (ack0),
      .ack1      (ack1),
      .rdata     (rdata),
      .busy      (busy),
      .can_ad_o  (can_ad_o),
      .can_ad_oe (can_ad_oe),
      .can_ad_i  (can_ad_i),
      .can_ale   (can_ale),
      .can_cs    (can_cs),
      .can_wr    (can_wr),
      .can_rd    (can_rd),
      .can_int   (can_int),
      .irq       (irq)
   );

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      int         port;
      logic [7:0] rd;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // ---------------- scoreboard monitor ----------------
   int cyc = 0;
   int last_ack_cyc = -1;
   always @(negedge clk) begin
      cyc++;
      if (rst_n && (ack0 || ack1)) begin
         chk("ack_onehot", int'(ack0 && ack1), 0);
         if (last_ack_cyc >= 0)
            chk("ack_spacing_ok", int'((cyc - last_ack_cyc) >= 11), 1);
         last_ack_cyc = cyc;
         if (sb.size() == 0) begin
            chk("unexpected_ack", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("ack_port", ack1 ? 1 : 0, e.port);
            chk("ack_rdata", int'(rdata), int'(e.rd));
         end
      end
   end

   // ---------------- requester driver ----------------
   task automatic xact(input int p, input logic w, input logic [7:0] a,
                       input logic [7:0] d);
      bit got;
      got = 1'b0;
      if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
      for (int i = 0; i < 64; i++) begin
         @(posedge clk); #1;
         if ((p == 0 && ack0) || (p == 1 && ack1)) begin
            got = 1'b1;
            break;
         end
      end
      chk($sformatf("xact_ack_seen_p%0d", p), int'(got), 1);
      @(posedge clk); #1;
      if (p == 0) req0 = 1'b0; else req1 = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: sim time exceeded");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int acks;
      rst_n = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      can_ad_i = 8'h00; can_int = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs",   int'(can_cs), 1);
      chk("rst_wr",   int'(can_wr), 1);
      chk("rst_rd",   int'(can_rd), 1);
      chk("rst_ale",  int'(can_ale), 0);
      chk("rst_oe",   int'(can_ad_oe), 0);
      chk("rst_ad_o", int'(can_ad_o), 0);
      chk("rst_ack",  int'({ack1, ack0}), 0);
      chk("rst_rdata", int'(rdata), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_irq",  int'(irq), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // ---- Test 1: write 0x5A to reg 0x04 via requester 0 ----
      req0 = 1; we0 = 1; addr0 = 8'h04; wdata0 = 8'h5A;
      sb.push_back('{0, 8'h00});
      for (int n = 1; n <= 11; n++) begin
         @(posedge clk); #1;
         chk($sformatf("t1_ale_c%0d", n),  int'(can_ale),   int'(n <= 2));
         chk($sformatf("t1_cs_c%0d", n),   int'(can_cs),    int'(!(n <= 7)));
         chk($sformatf("t1_wr_c%0d", n),   int'(can_wr),    int'(!(n >= 4 && n <= 6)));
         chk($sformatf("t1_rd_c%0d", n),   int'(can_rd),    1);
         chk($sformatf("t1_oe_c%0d", n),   int'(can_ad_oe), int'(n <= 7));
         chk($sformatf("t1_ack_c%0d", n),  int'(ack0),      int'(n == 8));
         chk($sformatf("t1_busy_c%0d", n), int'(busy),      int'(n <= 10));
         if (n <= 3)
            chk($sformatf("t1_ad_addr_c%0d", n), int'(can_ad_o), 8'h04);
         else if (n <= 7)
            chk($sformatf("t1_ad_data_c%0d", n), int'(can_ad_o), 8'h5A);
         if (n == 9) req0 = 0;
      end

      // ---- Test 2: read reg 0x02 via requester 1, device returns 0xC3 ----
      can_ad_i = 8'hC3;
      req1 = 1; we1 = 0; addr1 = 8'h02;
      sb.push_back('{1, 8'hC3});
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk); #1;
         chk($sformatf("t2_rd_c%0d", n),  int'(can_rd),    int'(!(n >= 4 && n <= 6)));
         chk($sformatf("t2_wr_c%0d", n),  int'(can_wr),    1);
         chk($sformatf("t2_oe_c%0d", n),  int'(can_ad_oe), int'(n <= 3));
         chk($sformatf("t2_ack_c%0d", n), int'(ack1),      int'(n == 8));
      end
      @(posedge clk); #1;
      req1 = 0;
      can_ad_i = 8'h00;
      @(posedge clk); #1;
      sb.push_back('{0, 8'hC3});
      xact(0, 1'b1, 8'h10, 8'h77);
      chk("t2_rdata_held", int'(rdata), 8'hC3);

      // ---- Test 3: contention ----
`ifdef CAN_ARB_RR_EN
      sb.push_back('{0, 8'hC3});
      sb.push_back('{1, 8'hC3});
      sb.push_back('{0, 8'hC3});
`else
      sb.push_back('{0, 8'hC3});
      sb.push_back('{0, 8'hC3});
      sb.push_back('{1, 8'hC3});
`endif
      fork
         begin
            xact(0, 1'b1, 8'h20, 8'hA1);
            xact(0, 1'b1, 8'h21, 8'hA2);
         end
         begin
            xact(1, 1'b1, 8'h30, 8'hB1);
         end
      join
      repeat (4) @(posedge clk);
      #1;

      // ---- Test 4: interrupt synchroniser ----
      can_int = 1'b0;
      chk("t4_irq_fall_e0", int'(irq), 0);
      @(posedge clk); #1;
      chk("t4_irq_fall_e1", int'(irq), 0);
      @(posedge clk); #1;
      chk("t4_irq_fall_e2", int'(irq), 1);
      can_int = 1'b1;
      @(posedge clk); #1;
      chk("t4_irq_rise_e1", int'(irq), 1);
      @(posedge clk); #1;
      chk("t4_irq_rise_e2", int'(irq), 0);

      // ---- Test 5: async reset during the 2nd strobe cycle of a write ----
      req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 8'h99;
      for (int i = 0; i < 32; i++) begin
         @(posedge clk); #1;
         if (!can_wr) break;
      end
      chk("t5_strobe_reached", int'(can_wr), 0);
      @(posedge clk); #1;
      chk("t5_strobe2_wr", int'(can_wr), 0);
      rst_n = 1'b0;
      req0 = 0;
      #1;
      chk("t5_wr_inactive",  int'(can_wr), 1);
      chk("t5_cs_inactive",  int'(can_cs), 1);
      chk("t5_oe_off",       int'(can_ad_oe), 0);
      chk("t5_ale_off",      int'(can_ale), 0);
      chk("t5_rdata_clr",    int'(rdata), 0);
      chk("t5_busy_clr",     int'(busy), 0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("t5_no_ack0", int'(ack0), 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      can_ad_i = 8'h3C;
      req1 = 1; we1 = 0; addr1 = 8'h05;
      sb.push_back('{1, 8'h3C});
      for (int n = 1; n <= 8; n++) begin
         @(posedge clk); #1;
         chk($sformatf("t5_ack1_c%0d", n), int'(ack1), int'(n == 8));
      end
      @(posedge clk); #1;
      req1 = 0;
      can_ad_i = 8'h00;
      repeat (3) @(posedge clk);
      #1;

      // ---- Test 6: requester withdraws after grant ----
      req0 = 1; we0 = 1; addr0 = 8'h50; wdata0 = 8'h66;
      sb.push_back('{0, 8'h3C});
      @(posedge clk); #1;
      chk("t6_granted_busy", int'(busy), 1);
      req0 = 0;
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (ack0) acks++;
      end
      chk("t6_ack0_once", acks, 1);

      repeat (4) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
